// File: rtl/floor_request_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// floor_request_scheduler_pkg
// Shared definitions for the call-button scheduler: the scheduler state
// encoding, the sweep-direction constants and the default door-dwell length.
// ----------------------------------------------------------------------------
package floor_request_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MOVE  = 2'd1,
        ST_DWELL = 2'd2
    } sched_state_e;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Door-open time in clock cycles at the board clock; simulations override it.
    localparam logic [31:0] DWELL_COUNT_DEFAULT = 32'd10000000;

endpackage

// File: rtl/floor_request_scheduler_button.sv
// ----------------------------------------------------------------------------
// button_sync_edge
// Brings a vector of asynchronous push buttons into the clock domain with a
// 2-FF synchroniser and emits a one-cycle pulse on each rising edge, so a held
// button produces exactly one pulse.
//
// Ports:
//   clk     - system clock
//   rst_n   - asynchronous active-low reset
//   i_btn   - raw button levels, one bit per button
//   o_rise  - one-cycle pulse per synchronised rising edge
// ----------------------------------------------------------------------------
module button_sync_edge
    import floor_request_scheduler_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_btn,
    output logic [WIDTH-1:0] o_rise
);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_s2_d;

    // NOTE: asynchronous reset is sampled in the sensitivity list; the
    // deassertion edge is assumed synchronised upstream by the board reset logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_s2_d <= '0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the old
            // value of its predecessor, which is what builds the shift chain.
            r_s1   <= i_btn;
            r_s2   <= r_s1;
            r_s2_d <= r_s2;
        end
    end

    // Edge flop restarts at 0 after reset, so a button held through reset
    // still yields a pulse once reset is released.
    assign o_rise = r_s2 & ~r_s2_d;

endmodule

// File: rtl/floor_request_scheduler.sv
// ----------------------------------------------------------------------------
// floor_request_scheduler
// Call-button front end for the elevator controller. Latches per-floor call
// requests, picks the next target with a SCAN (keep-direction) policy,
// retargets to closer floors on the way, clears a request on arrival and holds
// the door open for DWELL_COUNT cycles before the next move.
//
// Ports:
//   clk             - system clock
//   rst_n           - asynchronous active-low reset
//   call_btn        - raw call buttons, bit i = floor i
//   current_floor   - floor reported by the elevator controller
//   car_idle        - controller idle indication
//   requested_floor - registered target floor for the controller
//   pending         - latched, unserved requests
//   dir_up          - sweep direction, 1 = up
//   door_open       - high while the door dwell runs
// ----------------------------------------------------------------------------
module floor_request_scheduler
    import floor_request_scheduler_pkg::*;
#(
    parameter int          NUM_FLOORS  = 5,
    parameter int          FLOOR_W     = 4,
    parameter logic [31:0] DWELL_COUNT = DWELL_COUNT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] call_btn,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic                  car_idle,
    output logic [FLOOR_W-1:0]    requested_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  dir_up,
    output logic                  door_open
);

    typedef struct packed {
        logic               found;
        logic [FLOOR_W-1:0] floor;
    } pick_t;

    // Lowest pending floor f with lo < f < hi. Bounds are ints so -1 and
    // NUM_FLOORS can serve as open ends.
    function automatic pick_t lowest_between(input logic [NUM_FLOORS-1:0] req,
                                             input int lo, input int hi);
        pick_t p;
        p.found = 1'b0;
        p.floor = '0;
        for (int f = NUM_FLOORS - 1; f >= 0; f--) begin
            if (req[f] && (f > lo) && (f < hi)) begin
                p.found = 1'b1;
                p.floor = FLOOR_W'(f);
            end
        end
        return p;
    endfunction

    // Highest pending floor f with lo < f < hi.
    function automatic pick_t highest_between(input logic [NUM_FLOORS-1:0] req,
                                              input int lo, input int hi);
        pick_t p;
        p.found = 1'b0;
        p.floor = '0;
        for (int f = 0; f < NUM_FLOORS; f++) begin
            if (req[f] && (f > lo) && (f < hi)) begin
                p.found = 1'b1;
                p.floor = FLOOR_W'(f);
            end
        end
        return p;
    endfunction

    sched_state_e          r_state;
    logic [FLOOR_W-1:0]    r_req_floor;
    logic                  r_dir_up;
    logic [NUM_FLOORS-1:0] r_pending;
    logic [31:0]           r_dwell_cnt;

    sched_state_e          w_state_nxt;
    logic [FLOOR_W-1:0]    w_req_nxt;
    logic                  w_dir_nxt;
    logic [31:0]           w_dwell_nxt;
    logic [NUM_FLOORS-1:0] w_clr;
    logic [NUM_FLOORS-1:0] w_set;
    logic [NUM_FLOORS-1:0] w_rise;
    logic [NUM_FLOORS-1:0] w_cur_onehot;
    logic                  w_cur_valid;
    int                    w_cur_i;
    int                    w_req_i;
    pick_t                 w_above;
    pick_t                 w_below;
    pick_t                 w_fwd_up;
    pick_t                 w_fwd_dn;

    button_sync_edge #(
        .WIDTH (NUM_FLOORS)
    ) u_btn (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_btn  (call_btn),
        .o_rise (w_rise)
    );

    assign w_cur_i     = int'(current_floor);
    assign w_req_i     = int'(r_req_floor);
    // A controller fault can report a floor outside the building; such a
    // floor never matches a request bit and never triggers a clear.
    assign w_cur_valid = (w_cur_i < NUM_FLOORS);

    always_comb begin
        w_cur_onehot = '0;
        for (int f = 0; f < NUM_FLOORS; f++) begin
            w_cur_onehot[f] = (w_cur_i == f);
        end
    end

    // Presses for the floor whose door is open are already being served.
    assign w_set = w_rise & ~((r_state == ST_DWELL) ? w_cur_onehot : '0);

    // Out-of-range current_floor compares as above every real floor.
    assign w_above  = lowest_between(r_pending, w_cur_i, NUM_FLOORS);
    assign w_below  = highest_between(r_pending, -1, w_cur_i);
    assign w_fwd_up = lowest_between(r_pending, w_cur_i, w_req_i);
    assign w_fwd_dn = highest_between(r_pending, w_req_i, w_cur_i);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case leaves it unassigned and no latch is inferred.
        w_state_nxt = r_state;
        w_req_nxt   = r_req_floor;
        w_dir_nxt   = r_dir_up;
        w_dwell_nxt = r_dwell_cnt;
        w_clr       = '0;

        case (r_state)
            ST_IDLE: begin
                if (r_pending == '0) begin
                    w_req_nxt = current_floor;
                end else if (w_cur_valid && |(r_pending & w_cur_onehot)) begin
                    w_clr       = w_cur_onehot;
                    w_dwell_nxt = DWELL_COUNT - 32'd1;
                    w_state_nxt = ST_DWELL;
                end else begin
                    w_state_nxt = ST_MOVE;
                    if (r_dir_up == DIR_UP) begin
                        if (w_above.found) begin
                            w_req_nxt = w_above.floor;
                        end else begin
                            w_dir_nxt = DIR_DOWN;
                            w_req_nxt = w_below.floor;
                        end
                    end else begin
                        if (w_below.found) begin
                            w_req_nxt = w_below.floor;
                        end else begin
                            w_dir_nxt = DIR_UP;
                            w_req_nxt = w_above.floor;
                        end
                    end
                end
            end

            ST_MOVE: begin
                if (w_cur_valid && car_idle && (current_floor == r_req_floor)) begin
                    w_clr       = w_cur_onehot;
                    w_dwell_nxt = DWELL_COUNT - 32'd1;
                    w_state_nxt = ST_DWELL;
                end else if (w_cur_valid) begin
                    // Only pick up floors ahead of the car in the sweep direction.
                    if ((r_dir_up == DIR_UP) && w_fwd_up.found) begin
                        w_req_nxt = w_fwd_up.floor;
                    end else if ((r_dir_up == DIR_DOWN) && w_fwd_dn.found) begin
                        w_req_nxt = w_fwd_dn.floor;
                    end
                end
            end

            ST_DWELL: begin
                // Loaded with DWELL_COUNT-1, so the door stays open DWELL_COUNT cycles.
                if (r_dwell_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_dwell_nxt = r_dwell_cnt - 32'd1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_req_floor <= '0;
            r_dir_up    <= DIR_UP;
            r_pending   <= '0;
            r_dwell_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_floor <= w_req_nxt;
            r_dir_up    <= w_dir_nxt;
            r_dwell_cnt <= w_dwell_nxt;
            // Clear takes priority over a same-edge set of the same bit.
            r_pending   <= (r_pending | w_set) & ~w_clr;
        end
    end

    assign requested_floor = r_req_floor;
    assign pending         = r_pending;
    assign dir_up          = r_dir_up;
    assign door_open       = (r_state == ST_DWELL);

endmodule

// File: tb/tb_floor_request_scheduler.sv
// ----------------------------------------------------------------------------
// tb_floor_request_scheduler
// Drives the scheduler with a simple elevator-car model looped back to its
// current_floor/car_idle inputs, compares every cycle against a behavioural
// model of the request/SCAN/dwell rules, and pins that model with literal
// expectations from hand-worked scenarios, followed by random button traffic.
// ----------------------------------------------------------------------------
module tb_floor_request_scheduler;

    localparam int NF        = 5;
    localparam int FW        = 4;
    localparam int DW        = 8;
    localparam int CAR_DELAY = 4;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic [NF-1:0] call_btn = '0;
    logic [FW-1:0] current_floor;
    logic          car_idle;
    logic [FW-1:0] requested_floor;
    logic [NF-1:0] pending;
    logic          dir_up;
    logic          door_open;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    floor_request_scheduler #(
        .NUM_FLOORS  (NF),
        .FLOOR_W     (FW),
        .DWELL_COUNT (32'(DW))
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .call_btn        (call_btn),
        .current_floor   (current_floor),
        .car_idle        (car_idle),
        .requested_floor (requested_floor),
        .pending         (pending),
        .dir_up          (dir_up),
        .door_open       (door_open)
    );

    // ---------------- car model: one floor every CAR_DELAY cycles ----------
    logic [FW-1:0] car_floor  = '0;
    logic          car_idle_r = 1'b1;
    int            car_cnt    = 0;
    logic          fault      = 1'b0;

    assign current_floor = fault ? FW'(9) : car_floor;
    assign car_idle      = car_idle_r;

    always @(posedge clk) begin
        if ((requested_floor != car_floor) && (int'(requested_floor) < NF)) begin
            car_idle_r <= 1'b0;
            if (car_cnt == CAR_DELAY - 1) begin
                car_cnt   <= 0;
                car_floor <= (requested_floor > car_floor) ? car_floor + 4'd1 : car_floor - 4'd1;
            end else begin
                car_cnt <= car_cnt + 1;
            end
        end else begin
            car_idle_r <= 1'b1;
            car_cnt    <= 0;
        end
    end

    // ---------------- behavioural reference model ---------------------------
    logic [NF-1:0] m_pend;
    logic [FW-1:0] m_req;
    logic          m_dir;
    logic          m_moving;
    logic          m_dwelling;
    int            m_left;
    logic [NF-1:0] h1, h2, h3;   // button levels seen 1, 2, 3 edges ago
    int            served[$];    // floors whose door opened, in order

    function automatic int nearest_in_dir(input logic [NF-1:0] p, input int cur, input logic up);
        for (int d = 1; d <= 16; d++) begin
            int f;
            f = up ? cur + d : cur - d;
            if (f >= 0 && f < NF && p[f]) return f;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_pend = '0; m_req = '0; m_dir = 1'b1;
        m_moving = 1'b0; m_dwelling = 1'b0; m_left = 0;
        h1 = '0; h2 = '0; h3 = '0;
    endtask

    task automatic open_door(input int cur);
        m_moving   = 1'b0;
        m_dwelling = 1'b1;
        m_left     = DW;
        served.push_back(cur);
    endtask

    task automatic model_step();
        int            cur;
        int            tgt;
        logic [NF-1:0] rise;
        logic [NF-1:0] clr;
        cur  = int'(current_floor);
        // a press becomes a request on the third edge after the button rises
        rise = h2 & ~h3;
        h3 = h2; h2 = h1; h1 = call_btn;
        if (m_dwelling && cur < NF) rise = rise & ~(NF'(1) << cur);
        clr = '0;
        if (m_dwelling) begin
            m_left--;
            if (m_left == 0) m_dwelling = 1'b0;
        end else if (m_moving) begin
            if (cur < NF && car_idle && cur == int'(m_req)) begin
                clr = NF'(1) << cur;
                open_door(cur);
            end else if (cur < NF) begin
                if (m_dir) begin
                    for (int f = cur + 1; f < int'(m_req); f++) begin
                        if (m_pend[f]) begin m_req = FW'(f); break; end
                    end
                end else begin
                    for (int f = cur - 1; f > int'(m_req); f--) begin
                        if (m_pend[f]) begin m_req = FW'(f); break; end
                    end
                end
            end
        end else begin
            if (m_pend == '0) begin
                m_req = current_floor;
            end else if (cur < NF && m_pend[cur]) begin
                clr = NF'(1) << cur;
                open_door(cur);
            end else begin
                tgt = nearest_in_dir(m_pend, cur, m_dir);
                if (tgt < 0) begin
                    m_dir = ~m_dir;
                    tgt   = nearest_in_dir(m_pend, cur, m_dir);
                end
                m_req    = FW'(tgt);
                m_moving = 1'b1;
            end
        end
        m_pend = (m_pend | rise) & ~clr;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // ---------------- checking ----------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out waiting for DUT at %0t", name, $time);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                check("cyc_requested_floor", 32'(requested_floor), 32'(m_req));
                check("cyc_pending",         32'(pending),         32'(m_pend));
                check("cyc_dir_up",          32'(dir_up),          32'(m_dir));
                check("cyc_door_open",       32'(door_open),       32'(m_dwelling));
            end
        end
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic press(input logic [NF-1:0] mask);
        call_btn = mask;
        @(negedge clk);
        call_btn = '0;
        @(negedge clk);
    endtask

    task automatic wait_door(input string name);
        int n = 0;
        while (!door_open && n < 200) begin @(negedge clk); n++; end
        if (!door_open) timeout(name);
    endtask

    task automatic wait_quiet(input string name);
        int n = 0;
        @(negedge clk);
        while ((pending != '0 || door_open) && n < 600) begin @(negedge clk); n++; end
        if (pending != '0 || door_open) timeout(name);
    endtask

    task automatic wait_req(input string name, input logic [FW-1:0] f);
        int n = 0;
        while (requested_floor != f && n < 100) begin @(negedge clk); n++; end
        if (requested_floor != f) timeout(name);
    endtask

    task automatic wait_floor(input string name, input logic [FW-1:0] f);
        int n = 0;
        while (current_floor != f && n < 100) begin @(negedge clk); n++; end
        if (current_floor != f) timeout(name);
    endtask

    task automatic check_served(input string name, input int exp_q[$]);
        check({name, "_count"}, 32'(served.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < served.size(); i++)
            check({name, "_order"}, 32'(served[i]), 32'(exp_q[i]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- main sequence -----------------------------------------
    initial begin
        int n;
        repeat (2) @(negedge clk);
        check("rst_pending",   32'(pending),         32'd0);
        check("rst_req",       32'(requested_floor), 32'd0);
        check("rst_dir_up",    32'(dir_up),          32'd1);
        check("rst_door_open", 32'(door_open),       32'd0);
        cmp_en = 1'b1;
        rst_n  = 1'b1;
        repeat (2) @(negedge clk);

        // 1: single call to floor 3, latency and dwell length
        call_btn = 5'b01000;
        @(posedge clk);
        @(negedge clk); call_btn = '0;
        @(posedge clk); #1 check("t1_pend_edge1", 32'(pending), 32'd0);
        @(posedge clk); #1 check("t1_pend_edge2", 32'(pending), 32'b01000);
        @(posedge clk); #1 check("t1_req", 32'(requested_floor), 32'd3);
        check("t1_dir_up", 32'(dir_up), 32'd1);
        wait_door("t1_door");
        check("t1_arrive_floor", 32'(current_floor), 32'd3);
        check("t1_arrive_pend",  32'(pending),       32'd0);
        n = 0;
        while (door_open && n < 100) begin n++; @(negedge clk); end
        check("t1_dwell_cycles", 32'(n), 32'(DW));
        wait_quiet("t1_quiet");

        // 2: from floor 0 press 4 then 2 -> retarget, serve 2 then 4
        press(5'b00001); wait_quiet("t2_home");
        served.delete();
        press(5'b10000);
        wait_req("t2_go4", 4'd4);
        press(5'b00100);
        wait_req("t2_retarget", 4'd2);
        wait_quiet("t2_quiet");
        check_served("t2", '{2, 4});

        // 3: at 2 going up with {0,4} pending -> 4 first, then reverse to 0
        press(5'b00001); wait_quiet("t3_home");
        press(5'b00100); wait_door("t3_at2");
        check("t3_dir_at2", 32'(dir_up), 32'd1);
        served.delete();
        press(5'b10001);
        wait_quiet("t3_quiet");
        check_served("t3", '{4, 0});
        check("t3_dir_end", 32'(dir_up), 32'd0);

        // 4: presses during dwell at floor 2
        press(5'b00100); wait_door("t4_at2");
        served.delete();
        press(5'b00100);
        press(5'b00010);
        @(posedge clk); @(posedge clk); #1;
        check("t4_pend_dwell", 32'(pending),   32'b00010);
        check("t4_door_still", 32'(door_open), 32'd1);
        wait_quiet("t4_quiet");
        check_served("t4", '{1});

        // 6: press floor 0 while idle at floor 0 -> straight into dwell
        press(5'b00001); wait_quiet("t6_home");
        call_btn = 5'b00001;
        @(posedge clk);
        @(negedge clk); call_btn = '0;
        @(posedge clk); @(posedge clk); #1;
        check("t6_pend",     32'(pending),   32'b00001);
        check("t6_door_pre", 32'(door_open), 32'd0);
        @(posedge clk); #1;
        check("t6_door",     32'(door_open),       32'd1);
        check("t6_req",      32'(requested_floor), 32'd0);
        check("t6_pend_clr", 32'(pending),         32'd0);
        wait_quiet("t6_quiet");
        check("t6_req_end", 32'(requested_floor), 32'd0);

        // 5: reset mid-move toward 4 with {1,4} pending, button 1 held
        press(5'b10000);
        wait_floor("t5_floor2", 4'd2);
        call_btn = 5'b00010;
        repeat (3) @(posedge clk);
        #1 check("t5_pend_both", 32'(pending), 32'b10010);
        #1 rst_n = 1'b0;
        #1;
        check("t5_rst_pend", 32'(pending),         32'd0);
        check("t5_rst_req",  32'(requested_floor), 32'd0);
        check("t5_rst_dir",  32'(dir_up),          32'd1);
        check("t5_rst_door", 32'(door_open),       32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1 check("t5_rel_edge0", 32'(pending), 32'd0);
        @(posedge clk); #1 check("t5_rel_edge1", 32'(pending), 32'd0);
        @(posedge clk); #1 check("t5_rel_edge2", 32'(pending), 32'b00010);
        @(negedge clk); call_btn = '0;
        wait_quiet("t5_quiet");

        // controller fault: out-of-range floor during MOVE
        press(5'b10000);
        wait_req("tf_go4", 4'd4);
        fault = 1'b1;
        press(5'b01000);
        repeat (4) @(negedge clk);
        check("tf_req_hold", 32'(requested_floor), 32'd4);
        check("tf_no_door",  32'(door_open),       32'd0);
        fault = 1'b0;
        wait_quiet("tf_quiet");

        // random traffic, with one reset in the middle
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            call_btn = ($urandom_range(0, 7) == 0) ? NF'($urandom_range(1, 31)) : '0;
            if (c == 2000) rst_n = 1'b0;
            if (c == 2003) rst_n = 1'b1;
        end
        call_btn = '0;
        wait_quiet("rand_quiet");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
